// File: rtl/pd_pkg.sv
// Shared USB-PD definitions for the GoodCRC transmitter: FSM states,
// header field codes, CRC-32 constants and the header builder.
package pd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SEND_HDR0,
        SEND_HDR1,
        SEND_CRC,
        DONE,
        DISCARD
    } goodcrc_state_t;

    localparam logic [4:0] MSG_TYPE_GOODCRC = 5'b00001;

    localparam logic [1:0] SOP_TYPE_SOP     = 2'd0;
    localparam logic [1:0] SOP_TYPE_SOP_P   = 2'd1;
    localparam logic [1:0] SOP_TYPE_SOP_PP  = 2'd2;
    localparam logic [1:0] SOP_TYPE_ILLEGAL = 2'd3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);
    localparam logic [31:0] CRC32_INIT      = '1;

    // Role bits are only meaningful on SOP; cable plugs (SOP'/SOP'') carry 0.
    function automatic logic [15:0] goodcrc_header(
        input logic [2:0] msg_id,
        input logic [1:0] sop,
        input logic [1:0] rev,
        input logic       prole,
        input logic       drole
    );
        logic sop_hdr;
        sop_hdr = (sop == SOP_TYPE_SOP);
        return {1'b0, 3'b000, msg_id, prole & sop_hdr, rev, drole & sop_hdr,
                MSG_TYPE_GOODCRC};
    endfunction

endpackage

// File: rtl/goodcrc_tx_if.sv
// Byte-stream link between the GoodCRC transmitter and the PHY.
interface goodcrc_tx_if;
    logic       phy_bus_busy;
    logic       phy_tx_ready;
    logic [7:0] phy_tx_data;
    logic       phy_tx_valid;
    logic       phy_tx_eop;
    logic       phy_tx_abort;

    modport master (
        input  phy_bus_busy, phy_tx_ready,
        output phy_tx_data, phy_tx_valid, phy_tx_eop, phy_tx_abort
    );

    modport slave (
        output phy_bus_busy, phy_tx_ready,
        input  phy_tx_data, phy_tx_valid, phy_tx_eop, phy_tx_abort
    );
endinterface

// File: rtl/goodcrc_tx_crc32_byte_update.sv
// One-byte step of reflected CRC-32 (LSB of the byte first).
module crc32_byte_update
    import pd_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    // Shift the eight message bits through the reflected LFSR.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ byte_in[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/goodcrc_tx.sv
// GoodCRC transmitter: on a request edge builds the 2-byte GoodCRC header,
// streams header + CRC-32 to the PHY, and reports completion or discard.
module goodcrc_tx
    import pd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Send_GoodCRC_message_to_PHY,
    input  logic [2:0]        rx_msg_id,
    input  logic [1:0]        sop_type,
    input  logic [1:0]        spec_rev,
    input  logic              power_role,
    input  logic              data_role,
    goodcrc_tx_if.master      phy,
    output logic              GoodCRC_Transmission_complete,
    output logic              GoodCRC_Message_discarded_bus_Idle
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    goodcrc_state_t state, state_n;
    logic        req_q;
    logic        rise;
    logic [15:0] hdr;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] crc_fin;
    logic [7:0]  crc_byte_in;
    logic [1:0]  byte_idx;
    logic [7:0]  stall_cnt;
    logic        hs;
    logic        timeout_hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_eop;
    logic        tx_abort;

    assign rise        = Send_GoodCRC_message_to_PHY & ~req_q;
    assign crc_fin     = ~crc;
    assign crc_byte_in = (state == SEND_HDR1) ? hdr[15:8] : hdr[7:0];
    assign timeout_hit = (stall_cnt + 8'd1) >= TIMEOUT_LIM;

    crc32_byte_update u_crc (
        .crc_in  (crc),
        .byte_in (crc_byte_in),
        .crc_out (crc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode; a finished final byte wins over busy.
    always_comb begin
        state_n  = state;
        hs       = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_eop   = 1'b0;
        tx_abort = 1'b0;
        GoodCRC_Transmission_complete      = 1'b0;
        GoodCRC_Message_discarded_bus_Idle = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_n = LATCH;
            end
            LATCH: begin
                if (sop_type == SOP_TYPE_ILLEGAL || phy.phy_bus_busy) state_n = DISCARD;
                else                                                  state_n = SEND_HDR0;
            end
            SEND_HDR0, SEND_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = (state == SEND_HDR0) ? hdr[7:0] : hdr[15:8];
                hs       = phy.phy_tx_ready;
                if (phy.phy_bus_busy) state_n = DISCARD;
                else if (hs)          state_n = (state == SEND_HDR0) ? SEND_HDR1 : SEND_CRC;
                else if (timeout_hit) state_n = DISCARD;
            end
            SEND_CRC: begin
                tx_valid = 1'b1;
                tx_data  = crc_fin[{byte_idx, 3'b000} +: 8];
                tx_eop   = (byte_idx == 2'd3);
                hs       = phy.phy_tx_ready;
                if (hs && byte_idx == 2'd3) state_n = DONE;
                else if (phy.phy_bus_busy)  state_n = DISCARD;
                else if (!hs && timeout_hit) state_n = DISCARD;
            end
            DONE: begin
                GoodCRC_Transmission_complete = 1'b1;
                state_n = IDLE;
            end
            DISCARD: begin
                tx_abort = 1'b1;
                GoodCRC_Message_discarded_bus_Idle = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Edge detect, header/CRC capture, byte index and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= 1'b0;
            hdr       <= '0;
            crc       <= CRC32_INIT;
            byte_idx  <= '0;
            stall_cnt <= '0;
        end else begin
            req_q <= Send_GoodCRC_message_to_PHY;
            case (state)
                LATCH: begin
                    hdr       <= goodcrc_header(rx_msg_id, sop_type, spec_rev,
                                                power_role, data_role);
                    crc       <= CRC32_INIT;
                    byte_idx  <= '0;
                    stall_cnt <= '0;
                end
                SEND_HDR0, SEND_HDR1, SEND_CRC: begin
                    if (hs) begin
                        stall_cnt <= '0;
                        if (state == SEND_CRC) byte_idx <= byte_idx + 2'd1;
                        else                   crc      <= crc_next;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phy.phy_tx_data  = tx_data;
    assign phy.phy_tx_valid = tx_valid;
    assign phy.phy_tx_eop   = tx_eop;
    assign phy.phy_tx_abort = tx_abort;

endmodule

// File: tb/tb_goodcrc_tx.sv
// Randomized self-checking bench for goodcrc_tx against a cycle-timeline model.
module tb_goodcrc_tx;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [2:0] msg_id;
    logic [1:0] sop;
    logic [1:0] rev;
    logic       prole;
    logic       drole;
    logic       complete;
    logic       discarded;

    goodcrc_tx_if phy_bus();

    goodcrc_tx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                                (clk),
        .reset                              (reset),
        .Send_GoodCRC_message_to_PHY        (req),
        .rx_msg_id                          (msg_id),
        .sop_type                           (sop),
        .spec_rev                           (rev),
        .power_role                         (prole),
        .data_role                          (drole),
        .phy                                (phy_bus),
        .GoodCRC_Transmission_complete      (complete),
        .GoodCRC_Message_discarded_bus_Idle (discarded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         stall_len[6];
    int         obs_done_c;
    int         obs_disc_c;
    logic [7:0] obs_bytes[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < obs_bytes.size()) return obs_bytes[i];
        return 8'hxx;
    endfunction

    // Header from the field rules with plain arithmetic.
    function automatic logic [15:0] ref_hdr(input logic [2:0] id, input logic [1:0] st,
                                            input logic [1:0] rv, input logic p, input logic d);
        int h;
        h = 1 + int'(rv) * 64 + int'(id) * 512;
        if (st == 2'd0) h = h + int'(d) * 32 + int'(p) * 256;
        return 16'(h);
    endfunction

    // CRC-32 in the non-reflected MSB-first form, fed bits in wire order,
    // then reflected and complemented.
    function automatic logic [31:0] ref_crc(input logic [15:0] msg);
        logic [31:0] c;
        logic [31:0] r;
        logic        top;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 16; i++) begin
            top = c[31] ^ msg[i];
            c = c << 1;
            if (top) c = c ^ 32'h04C11DB7;
        end
        for (int i = 0; i < 32; i++) r[i] = c[31 - i];
        return ~r;
    endfunction

    task automatic run_txn(input logic [2:0] id, input logic [1:0] st, input logic [1:0] rv,
                           input logic p, input logic d, input int busy_c, input int reset_c,
                           input bit retrig);
        int          start_c[6];
        logic [7:0]  eb[6];
        logic [15:0] h;
        logic [31:0] cr;
        int          term;
        int          s;
        int          c_last;
        int          idx;
        bit          ok_done;
        bit          cut;
        bit          e_valid;
        logic        rdy;

        h  = ref_hdr(id, st, rv, p, d);
        cr = ref_crc(h);
        eb[0] = h[7:0];
        eb[1] = h[15:8];
        for (int k = 0; k < 4; k++) eb[2 + k] = cr[8 * k +: 8];
        obs_bytes.delete();
        obs_done_c = -1;
        obs_disc_c = -1;

        if (st == 2'd3) begin
            term = 2;
            ok_done = 1'b0;
            for (int k = 0; k < 6; k++) start_c[k] = 1000;
        end else begin
            s = 2;
            term = -1;
            for (int k = 0; k < 6; k++) begin
                if (term >= 0) start_c[k] = 1000;
                else begin
                    start_c[k] = s;
                    if (stall_len[k] >= TO) term = s + TO;
                    else s = s + stall_len[k] + 1;
                end
            end
            if (term < 0) begin
                term = s;
                ok_done = 1'b1;
            end else begin
                ok_done = 1'b0;
            end
            if (busy_c >= 1 && busy_c <= term - (ok_done ? 2 : 1)) begin
                term = busy_c + 1;
                ok_done = 1'b0;
            end
        end
        c_last = (reset_c >= 0 && reset_c < term) ? reset_c + 2 : term + 2;

        // cycle 0: request edge
        msg_id = id; sop = st; rev = rv; prole = p; drole = d;
        req = 1'b1;
        phy_bus.phy_bus_busy = (busy_c == 0);
        phy_bus.phy_tx_ready = 1'b1;

        for (int c = 1; c <= c_last; c++) begin
            @(posedge clk);
            #1;
            rdy = 1'b1;
            for (int k = 0; k < 6; k++)
                if (start_c[k] <= c && c < start_c[k] + stall_len[k]) rdy = 1'b0;
            phy_bus.phy_tx_ready = rdy;
            phy_bus.phy_bus_busy = (c == busy_c);
            reset = (c == reset_c);
            if (reset_c >= 0 && c >= reset_c) req = 1'b0;
            else if (retrig && term >= 5 && c == 3) req = 1'b0;
            else req = 1'b1;

            cut = (reset_c >= 0 && reset_c < term && c > reset_c);
            e_valid = !cut && st != 2'd3 && c >= 2 && c < term;
            idx = 0;
            for (int k = 0; k < 6; k++) if (start_c[k] <= c) idx = k;

            check_eq($sformatf("valid c%0d", c), phy_bus.phy_tx_valid, e_valid);
            if (e_valid) begin
                check_eq($sformatf("data c%0d b%0d", c, idx), phy_bus.phy_tx_data, eb[idx]);
                check_eq($sformatf("eop c%0d", c), phy_bus.phy_tx_eop, idx == 5);
            end else begin
                check_eq($sformatf("eop_idle c%0d", c), phy_bus.phy_tx_eop, 1'b0);
            end
            check_eq($sformatf("complete c%0d", c), complete, !cut && ok_done && c == term);
            check_eq($sformatf("discard c%0d", c), discarded, !cut && !ok_done && c == term);
            check_eq($sformatf("abort c%0d", c), phy_bus.phy_tx_abort, !cut && !ok_done && c == term);

            if (complete) obs_done_c = c;
            if (discarded) obs_disc_c = c;
            if (phy_bus.phy_tx_valid && rdy) obs_bytes.push_back(phy_bus.phy_tx_data);
        end

        req = 1'b0;
        reset = 1'b0;
        phy_bus.phy_bus_busy = 1'b0;
        phy_bus.phy_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_after valid", phy_bus.phy_tx_valid, 1'b0);
        check_eq("idle_after pulses", {complete, discarded}, 2'b00);
    endtask

    task automatic clear_stalls();
        for (int k = 0; k < 6; k++) stall_len[k] = 0;
    endtask

    initial begin
        int r;
        int b_c;
        int r_c;
        logic [1:0] st;

        reset = 1'b1; req = 1'b0;
        msg_id = '0; sop = '0; rev = '0; prole = 1'b0; drole = 1'b0;
        phy_bus.phy_bus_busy = 1'b0;
        phy_bus.phy_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset valid", phy_bus.phy_tx_valid, 1'b0);
        check_eq("reset eop", phy_bus.phy_tx_eop, 1'b0);
        check_eq("reset abort", phy_bus.phy_tx_abort, 1'b0);
        check_eq("reset data", phy_bus.phy_tx_data, 8'h00);
        check_eq("reset pulses", {complete, discarded}, 2'b00);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // SOP, id 5, rev 2, roles 1
        clear_stalls();
        run_txn(3'd5, 2'd0, 2'd2, 1'b1, 1'b1, -1, -1, 1'b0);
        check_eq("sop byte0", byte_at(0), 8'hA1);
        check_eq("sop byte1", byte_at(1), 8'h0B);
        check_eq("sop nbytes", obs_bytes.size(), 6);
        check_eq("sop done cycle", obs_done_c, 8);

        // SOP', role bits forced to 0
        run_txn(3'd5, 2'd1, 2'd2, 1'b1, 1'b1, -1, -1, 1'b0);
        check_eq("sopp byte0", byte_at(0), 8'h81);
        check_eq("sopp byte1", byte_at(1), 8'h0A);

        // ready low 3 cycles on byte 2
        stall_len[1] = 3;
        run_txn(3'd5, 2'd0, 2'd2, 1'b1, 1'b1, -1, -1, 1'b0);
        check_eq("stall done cycle", obs_done_c, 11);
        clear_stalls();

        // busy during byte 3
        run_txn(3'd2, 2'd0, 2'd1, 1'b0, 1'b1, 4, -1, 1'b0);
        check_eq("busy discard cycle", obs_disc_c, 5);
        check_eq("busy no complete", obs_done_c, -1);

        // busy on the final handshake: completion wins
        run_txn(3'd2, 2'd0, 2'd1, 1'b0, 1'b1, 7, -1, 1'b0);
        check_eq("busy last done cycle", obs_done_c, 8);

        // timeout on first byte
        stall_len[0] = TO;
        run_txn(3'd1, 2'd2, 2'd3, 1'b1, 1'b0, -1, -1, 1'b0);
        check_eq("timeout discard cycle", obs_disc_c, 6);
        clear_stalls();

        // reset mid-send
        run_txn(3'd7, 2'd0, 2'd2, 1'b1, 1'b1, -1, 4, 1'b0);
        check_eq("reset mid no pulses", obs_done_c + obs_disc_c, -2);

        // illegal sop type
        run_txn(3'd3, 2'd3, 2'd2, 1'b1, 1'b1, -1, -1, 1'b0);
        check_eq("sop3 discard cycle", obs_disc_c, 2);
        check_eq("sop3 no bytes", obs_bytes.size(), 0);

        // request edge while busy sending is not queued
        run_txn(3'd4, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1, 1'b1);

        for (int t = 0; t < 150; t++) begin
            for (int k = 0; k < 6; k++) begin
                r = $urandom_range(0, 9);
                if (r < 6) stall_len[k] = 0;
                else if (r < 9) stall_len[k] = $urandom_range(1, TO - 1);
                else stall_len[k] = $urandom_range(TO, TO + 2);
            end
            b_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            r_c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 10)) : -1;
            st = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_txn(3'($urandom), st, 2'($urandom), 1'($urandom), 1'($urandom),
                    b_c, r_c, 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
